// File: rtl/plot_framebuffer.sv
// plot_framebuffer: 160x120 pixel store with plot port, bulk clear and raster scan-out.
// Optional saturating rejected-plot counter: define PLOT_FRAMEBUFFER_DROP_COUNT_EN.
module plot_framebuffer #(
    parameter int H_RES    = 160,
    parameter int V_RES    = 120,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          vga_x,
    input  logic [6:0]          vga_y,
    input  logic [COLOUR_W-1:0] vga_colour,
    input  logic                vga_plot,
    input  logic                clear_req,
    input  logic [COLOUR_W-1:0] clear_colour,
    input  logic                scan_start,
    output logic                busy,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [7:0]          pix_x,
    output logic [6:0]          pix_y,
    output logic [COLOUR_W-1:0] pix_colour,
    output logic                pix_last
`ifdef PLOT_FRAMEBUFFER_DROP_COUNT_EN
    ,
    output logic [15:0]         drop_count
`endif
);
    localparam int DEPTH = H_RES * V_RES;
    localparam int AW    = 15;

    typedef enum logic [1:0] {IDLE, CLEAR, SCAN_RD, SCAN_OUT} state_t;

    state_t              state_q, state_d;
    logic [7:0]          x_q, x_d;
    logic [6:0]          y_q, y_d;
    logic [AW-1:0]       caddr_q, caddr_d;
    logic [COLOUR_W-1:0] ccol_q, ccol_d;
    logic [COLOUR_W-1:0] rd_q;
    logic [COLOUR_W-1:0] mem [DEPTH];

    logic                in_range, plot_ok, we, last, x_end;
    logic [AW-1:0]       paddr, saddr, waddr;
    logic [COLOUR_W-1:0] wdata;

    assign in_range = (32'(vga_x) < H_RES) && (32'(vga_y) < V_RES);
    assign plot_ok  = vga_plot && in_range && (state_q != CLEAR);
    assign paddr    = AW'(vga_y) * AW'(H_RES) + AW'(vga_x);
    assign saddr    = AW'(y_q) * AW'(H_RES) + AW'(x_q);
    assign we       = (state_q == CLEAR) || plot_ok;
    assign waddr    = (state_q == CLEAR) ? caddr_q : paddr;
    assign wdata    = (state_q == CLEAR) ? ccol_q : vga_colour;
    assign x_end    = x_q == 8'(H_RES - 1);
    assign last     = x_end && (y_q == 7'(V_RES - 1));

    // Store has no reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rd_q <= '0;
        else if (state_q == SCAN_RD) rd_q <= mem[saddr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            caddr_q <= '0;
            ccol_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            caddr_q <= caddr_d;
            ccol_q  <= ccol_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        caddr_d = caddr_q;
        ccol_d  = ccol_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    caddr_d = '0;
                    ccol_d  = clear_colour;
                end else if (scan_start) begin
                    state_d = SCAN_RD;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            CLEAR: begin
                caddr_d = caddr_q + 1'b1;
                if (caddr_q == AW'(DEPTH - 1)) state_d = IDLE;
            end
            SCAN_RD: state_d = SCAN_OUT;
            SCAN_OUT: begin
                if (pix_ready) begin
                    state_d = last ? IDLE : SCAN_RD;
                    x_d     = last ? x_q : (x_end ? '0 : x_q + 1'b1);
                    y_d     = (x_end && !last) ? y_q + 1'b1 : y_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = state_q != IDLE;
    assign pix_valid  = state_q == SCAN_OUT;
    assign pix_x      = x_q;
    assign pix_y      = y_q;
    assign pix_colour = rd_q;
    assign pix_last   = pix_valid && last;

`ifdef PLOT_FRAMEBUFFER_DROP_COUNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk) begin
        if (!rst_n) drop_q <= '0;
        else if (vga_plot && !plot_ok && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
    end

    assign drop_count = drop_q;
`endif
endmodule

// File: doc/plot_framebuffer.md
Name: plot_framebuffer

Overview:
- Consumer end of the pixel-plot interface driven by the circle, Reuleaux and fill drawers.
- Accepts one (vga_x, vga_y, vga_colour, vga_plot) write per cycle into a 160x120x3 frame store.
- Provides a bulk clear engine and a raster-order scan-out reader with a valid/ready handshake, for the display or a checker.

Parameters:
- H_RES, 160, pixels per line; valid x is 0..H_RES-1.
- V_RES, 120, lines per frame; valid y is 0..V_RES-1.
- COLOUR_W, 3, bits per pixel.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- vga_x  in  8  plot x
- vga_y  in  7  plot y
- vga_colour  in  COLOUR_W  plot colour
- vga_plot  in  1  plot strobe, one write per high cycle
- clear_req  in  1  start full-frame clear (pulse)
- clear_colour  in  COLOUR_W  fill value for clear
- scan_start  in  1  start raster scan-out (pulse)
- busy  out  1  high in CLEAR or SCAN
- pix_valid  out  1  scan pixel available
- pix_ready  in  1  downstream accepts pixel
- pix_x  out  8  x of presented pixel
- pix_y  out  7  y of presented pixel
- pix_colour  out  COLOUR_W  stored colour
- pix_last  out  1  presented pixel is (H_RES-1, V_RES-1)
- drop_count  out  16  rejected plots, saturating (DROP_COUNT_EN only)

Behaviour:
- Storage: H_RES*V_RES entries, address = y*H_RES + x.
  - Separate write and read ports; read latency 1 cycle.
  - Same-cycle same-address read returns the old data.
  - Contents are undefined after reset; reset does not clear the store.
- Reset: state IDLE; busy, pix_valid and pix_last are 0; pix_x, pix_y and pix_colour are 0; drop_count is 0; scan and clear counters are 0.
- Plot write:
  - Sampled on each rising edge with vga_plot=1.
  - Committed at that edge if x<H_RES, y<V_RES and state is not CLEAR.
  - Otherwise dropped.
  - Writes are accepted in IDLE and SCAN; scan-out is not frame-coherent.
- FSM states: IDLE, CLEAR, SCAN_RD, SCAN_OUT.
- IDLE:
  - clear_req=1 -> CLEAR with the clear address at 0 and clear_colour latched.
  - Else scan_start=1 -> SCAN_RD with the scan position at (0,0).
  - clear_req takes priority if both are high.
  - clear_req and scan_start are ignored in every other state; there is no queueing.
- CLEAR:
  - Writes the latched colour to one address per cycle, 0..H_RES*V_RES-1.
  - The cycle after writing the last address -> IDLE.
  - Total 19200 cycles with busy=1.
- SCAN_RD: issues a read of the current position; next state is SCAN_OUT.
- SCAN_OUT:
  - pix_valid=1; pix_x, pix_y, pix_colour and pix_last stay stable until pix_ready=1.
  - On pix_valid&&pix_ready: if pix_last -> IDLE, else advance the position and go to SCAN_RD.
  - Position advances x+1; at x=H_RES-1, x wraps to 0 and y increments.
  - pix_valid deasserts the cycle after acceptance.
  - Peak throughput is one pixel per 2 cycles.
- busy=1 in CLEAR, SCAN_RD and SCAN_OUT.
- Synchronous reset mid-CLEAR or mid-SCAN returns to IDLE next edge with all outputs at reset values. A partially cleared frame is left as-is.
- Width rule: address arithmetic is carried at 15 bits; x and y are compared unsigned. Negative coordinates from drawers arrive as large unsigned values and are rejected as out-of-range.

Optional Feature:
- Macro: PLOT_FRAMEBUFFER_DROP_COUNT_EN.
- Defined:
  - drop_count port present.
  - Increments by 1 on each vga_plot=1 cycle that is rejected (out of range, or during CLEAR).
  - Saturates at 16'hFFFF.
  - Reset to 0 only by rst_n.
- Undefined: port and counter absent; drop behaviour is otherwise identical.

Test Plan:
- Clear colour 3'b101, then scan with pix_ready held 1:
  - busy high for exactly 19200 cycles during the clear.
  - Scan yields 19200 pixels, all 3'b101, in raster order.
  - pix_last high only at (159,119).
  - busy falls the cycle after the last accept.
- After a clear to 0, plot (10,20)=3'b011 and (159,119)=3'b111, then scan:
  - Exactly those two pixels are non-zero.
  - pix_last coincides with the 3'b111 pixel.
- Plot (160,5), (5,120) and (255,127), each with vga_plot=1, then scan:
  - No store change.
  - drop_count=3 with macro enabled.
- Plot (0,0) pulses during CLEAR:
  - Plots are dropped; the pixel ends at clear_colour.
  - drop_count increments once per pulse.
- Scan with pix_ready held 0 for 7 cycles at pixel (3,0):
  - pix_valid, pix_x=3, pix_y=0 and pix_colour stay stable.
  - The next pixel appears only after the accept.
- Assert rst_n=0 for 1 cycle at pixel (50,60) of a scan:
  - Next cycle busy=0, pix_valid=0, outputs at 0.
  - Then scan_start restarts at (0,0).
